// File: rtl/scr1_mtimer_mmio.sv
// scr1_mtimer_mmio: memory-mapped machine timer on the DMEM timer port.
// It holds a 64-bit mtime counter that advances through a programmable
// prescaler. The tick source is either clk or a synchronized rtc_clk.
// The mtimer interrupt is raised when mtime >= mtimecmp.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        synchronous active-low reset
//   i_rtc_clk      real-time clock, sampled as data in the clk domain
//   i_dmem_req     request valid
//   i_dmem_cmd     0=RD, 1=WR
//   i_dmem_width   0=BYTE, 1=HWORD, 2=WORD
//   i_dmem_addr    byte address
//   i_dmem_wdata   write data
//   o_dmem_req_ack request accepted (always 1)
//   o_dmem_rdata   read data, one cycle after acceptance
//   o_dmem_resp    0=IDLE, 1=RDY, 2=ER, one cycle after acceptance
//   o_timer_irq    registered mtime >= mtimecmp
//   o_timer_val    current mtime
//
// Register window (offsets from SCR1_TIMER_BASE):
//   0x00 CONTROL     bit0 enable, bit1 clksrc (0=clk, 1=rtc)
//   0x04 DIVIDER     [SCR1_TIMER_DIV_W-1:0]
//   0x08 MTIMELO     0x0C MTIMEHI
//   0x10 MTIMECMPLO  0x14 MTIMECMPHI
module scr1_mtimer_mmio #(
  parameter logic [31:0] SCR1_TIMER_BASE      = 32'hF004_0000,
  parameter int unsigned SCR1_TIMER_DIV_W     = 10,
  parameter int unsigned SCR1_RTC_SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rtc_clk,
  input  logic        i_dmem_req,
  input  logic        i_dmem_cmd,
  input  logic [1:0]  i_dmem_width,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  output logic        o_dmem_req_ack,
  output logic [31:0] o_dmem_rdata,
  output logic [1:0]  o_dmem_resp,
  output logic        o_timer_irq,
  output logic [63:0] o_timer_val
);

  localparam int unsigned DIV_W  = SCR1_TIMER_DIV_W;
  localparam int unsigned SYNC_W = SCR1_RTC_SYNC_STAGES;

  localparam logic       CMD_WR     = 1'b1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;
  localparam logic [1:0] RESP_IDLE  = 2'd0;
  localparam logic [1:0] RESP_RDY   = 2'd1;
  localparam logic [1:0] RESP_ER    = 2'd2;

  localparam logic [2:0] SEL_CTRL = 3'd0;
  localparam logic [2:0] SEL_DIV  = 3'd1;
  localparam logic [2:0] SEL_MLO  = 3'd2;
  localparam logic [2:0] SEL_MHI  = 3'd3;
  localparam logic [2:0] SEL_CLO  = 3'd4;
  localparam logic [2:0] SEL_CHI  = 3'd5;

  // Architectural state.
  logic              r_en;
  logic              r_src;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [63:0]       r_mtime;
  logic [63:0]       r_mtimecmp;
  logic              r_irq;
  logic [1:0]        r_resp;
  logic [31:0]       r_rdata;
  logic [SYNC_W-1:0] r_rtc_sync;
  logic              r_rtc_prev;

  // Request decode.
  logic             w_in_win;
  logic             w_ok;
  logic             w_rd;
  logic             w_wr;
  logic [2:0]       w_sel;
  logic             w_wr_ctrl;
  logic             w_wr_div;
  logic             w_wr_mlo;
  logic             w_wr_mhi;
  logic             w_wr_clo;
  logic             w_wr_chi;
  logic [31:0]      w_rdata;
  logic             w_tick;
  logic             w_rtc_s;
  logic [DIV_W-1:0] w_div_cnt_nxt;
  logic [63:0]      w_mtime_nxt;

  assign o_dmem_req_ack = 1'b1;
  assign o_dmem_rdata   = r_rdata;
  assign o_dmem_resp    = r_resp;
  assign o_timer_irq    = r_irq;
  assign o_timer_val    = r_mtime;

  // Window hit: same 64-byte block as the base, and offset below 0x18.
  assign w_in_win = (i_dmem_addr[31:6] == SCR1_TIMER_BASE[31:6]) &&
                    (i_dmem_addr[5:0] < 6'h18);
  assign w_ok     = w_in_win && (i_dmem_width == WIDTH_WORD) &&
                    (i_dmem_addr[1:0] == 2'b00);
  assign w_rd     = i_dmem_req && w_ok && (i_dmem_cmd != CMD_WR);
  assign w_wr     = i_dmem_req && w_ok && (i_dmem_cmd == CMD_WR);
  assign w_sel    = i_dmem_addr[4:2];

  assign w_wr_ctrl = w_wr && (w_sel == SEL_CTRL);
  assign w_wr_div  = w_wr && (w_sel == SEL_DIV);
  assign w_wr_mlo  = w_wr && (w_sel == SEL_MLO);
  assign w_wr_mhi  = w_wr && (w_sel == SEL_MHI);
  assign w_wr_clo  = w_wr && (w_sel == SEL_CLO);
  assign w_wr_chi  = w_wr && (w_sel == SEL_CHI);

  // Read data mux.
  always_comb begin
    w_rdata = 32'd0;
    case (w_sel)
      SEL_CTRL: w_rdata = {30'd0, r_src, r_en};
      SEL_DIV:  w_rdata = 32'(r_div);
      SEL_MLO:  w_rdata = r_mtime[31:0];
      SEL_MHI:  w_rdata = r_mtime[63:32];
      SEL_CLO:  w_rdata = r_mtimecmp[31:0];
      SEL_CHI:  w_rdata = r_mtimecmp[63:32];
      default:  w_rdata = 32'd0;
    endcase
  end

  // Tick: every clk, or one per synchronized rtc_clk rising edge.
  assign w_rtc_s = r_rtc_sync[SYNC_W-1];
  assign w_tick  = r_src ? (w_rtc_s && !r_rtc_prev) : 1'b1;

  // Prescaler and mtime next state. Any write to CONTROL, DIVIDER or
  // mtime restarts the prescaler and skips this cycle's increment.
  always_comb begin
    w_div_cnt_nxt = r_div_cnt;
    w_mtime_nxt   = r_mtime;
    if (r_en && w_tick) begin
      if (r_div_cnt == r_div) begin
        w_div_cnt_nxt = '0;
        w_mtime_nxt   = r_mtime + 64'd1;
      end else begin
        w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
      end
    end
    if (w_wr_ctrl || w_wr_div || w_wr_mlo || w_wr_mhi) begin
      w_div_cnt_nxt = '0;
      w_mtime_nxt   = r_mtime;
    end
    if (w_wr_mlo) w_mtime_nxt[31:0]  = i_dmem_wdata;
    if (w_wr_mhi) w_mtime_nxt[63:32] = i_dmem_wdata;
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_en       <= 1'b1;
      r_src      <= 1'b0;
      r_div      <= '0;
      r_div_cnt  <= '0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
      r_resp     <= RESP_IDLE;
      r_rdata    <= 32'd0;
      r_rtc_sync <= '0;
      r_rtc_prev <= 1'b0;
    end else begin
      r_rtc_sync <= SYNC_W'({r_rtc_sync, i_rtc_clk});
      r_rtc_prev <= w_rtc_s;
      r_div_cnt  <= w_div_cnt_nxt;
      r_mtime    <= w_mtime_nxt;
      r_irq      <= (r_mtime >= r_mtimecmp);
      if (w_wr_ctrl) begin
        r_en  <= i_dmem_wdata[0];
        r_src <= i_dmem_wdata[1];
      end
      if (w_wr_div) r_div <= i_dmem_wdata[DIV_W-1:0];
      if (w_wr_clo) r_mtimecmp[31:0]  <= i_dmem_wdata;
      if (w_wr_chi) r_mtimecmp[63:32] <= i_dmem_wdata;
      // Single-cycle response; rdata is zero except on a successful read.
      if (!i_dmem_req) r_resp <= RESP_IDLE;
      else if (w_ok)   r_resp <= RESP_RDY;
      else             r_resp <= RESP_ER;
      r_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

endmodule
